sram_bridge_arb: RTL and testbench
==================================

Name: sram_bridge_arb

Overview:
- Parametrised bridge between the CPU's SRAM-style instruction/data ports and the two cache ports.
- Per CPU step, serialises at most one data access and one instruction fetch onto the caches.
- Holds the pipeline with a single stall until both complete.
- Adds over the prior interface:
  - registered request capture
  - configurable data/instruction order
  - flush-safe refetch
  - per-request timeout with bus error reporting

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width (multiple of 8).
- BE_W, DATA_W/8, byte-enable width.
- DATA_FIRST, 1, 1 = data access before fetch; 0 = fetch before data.
- TIMEOUT, 0, max wait cycles per request; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush; in-flight fetch result becomes stale
- cpu_inst_addr  in  ADDR_W  fetch address
- cpu_inst_rdata  out  DATA_W  fetched word, held until next capture
- cpu_data_addr  in  ADDR_W  data address
- cpu_data_ren  in  1  data read request
- cpu_data_wen  in  BE_W  byte write enables; nonzero = write
- cpu_data_wdata  in  DATA_W  write data
- cpu_data_rdata  out  DATA_W  read data, held until next capture
- cpu_stall  out  1  stall to pipeline
- bus_err  out  1  one-cycle pulse on timeout
- inst_addr  out  ADDR_W  cache fetch address (registered)
- inst_ren  out  1  cache fetch request, level-held until inst_valid
- inst_valid  in  1  fetch done, inst_rd valid
- inst_rd  in  DATA_W  fetch data
- data_addr  out  ADDR_W  cache data address (registered)
- data_ren  out  1  cache read request, level-held until data_valid
- data_wen  out  BE_W  cache write enables, level-held until data_valid
- data_wd  out  DATA_W  cache write data
- data_valid  in  1  data op done
- data_rd  in  DATA_W  read data

Behaviour:
- Reset:
  - state=IDLE, cpu_stall=1.
  - All other outputs 0, including the rdata hold registers.
  - Internal flags (d_done, i_done, stale) and wait counter cleared.
  - rst mid-transaction abandons it; a late valid after reset is ignored in IDLE.
- States: IDLE, ARB, DWAIT, IWAIT, DONE. All outputs registered. cpu_stall=0 only in DONE.
- IDLE -> ARB unconditionally, one cycle after reset release.
- ARB:
  - Data op pending = (cpu_data_ren | |cpu_data_wen) & !d_done & !flush.
  - Capture data addr/wen/wdata into the data_* output regs, or cpu_inst_addr into inst_addr, per the chosen op.
  - DATA_FIRST=1: data pending -> DWAIT; else if !i_done -> IWAIT; else -> DONE.
  - DATA_FIRST=0: fetch is checked first, then data.
  - If ren and wen are both set, ren wins and the write is dropped. This is a CPU protocol error.
- DWAIT:
  - data_ren or data_wen held until data_valid is sampled high.
  - On data_valid: capture data_rd into cpu_data_rdata (reads only), set d_done, clear data_ren/data_wen.
  - Then go to IWAIT with the fetch request issued directly if !i_done, else DONE.
- IWAIT:
  - inst_ren held until inst_valid.
  - On inst_valid with stale=0: capture inst_rd, set i_done, then go to DWAIT (direct issue) if a data op is still pending (DATA_FIRST=0 case), else DONE.
  - On inst_valid with stale=1: discard inst_rd, clear stale, return to ARB, which refetches from the current cpu_inst_addr.
- DONE: single cycle with cpu_stall=0; clear d_done and i_done; -> ARB.
- Flush:
  - flush high in any cycle of IWAIT sets stale, including the cycle inst_valid arrives; that result is discarded.
  - flush in DWAIT does not abort the issued data op; it completes normally.
  - flush in ARB suppresses a not-yet-issued data op.
- Handshake: the cache may assert valid earliest one cycle after the request is visible. Requests are never withdrawn before valid, except on timeout or rst.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to DWAIT/IWAIT and increments each waiting cycle.
  - When count==TIMEOUT-1 without valid: drop the request, pulse bus_err, load 0 into the corresponding rdata register, mark the op done, and continue as if valid had arrived.
- Latency, fetch only, valid in first wait cycle: ARB c0, IWAIT c1, DONE c2 (stall low), ARB c3.
  - With a preceding data op: +1 cycle per data wait cycle.

Test Plan:
- Fetch only, DATA_FIRST=1: cpu_inst_addr=0xBFC00000, inst_valid one cycle after inst_ren, inst_rd=0x24080001 -> cpu_stall low exactly at c2, cpu_inst_rdata=0x24080001, data_ren/data_wen never asserted.
- Load then fetch: cpu_data_ren=1, addr=0x80001000, data_rd=0xDEADBEEF after 3 wait cycles -> data_ren high 3 cycles, inst_ren rises the cycle after data_valid, cpu_data_rdata=0xDEADBEEF, single stall release.
- Byte store with DATA_FIRST=0: wen=4'b0010, wdata=0x0000AB00 -> fetch first, then data_wen=0010 and data_wd=0x0000AB00 held until data_valid; cpu_data_rdata unchanged.
- Flush during IWAIT: flush pulse at wait cycle 2, addr changed to 0xBFC00380 -> first inst_rd discarded, second fetch to 0xBFC00380, its data delivered, no stall release in between.
- Timeout with TIMEOUT=8, inst_valid never asserted -> inst_ren drops after 8 wait cycles, bus_err high 1 cycle, cpu_inst_rdata=0, DONE follows.
- rst asserted mid-DWAIT with a late data_valid -> all outputs at reset values next cycle, cpu_stall=1, late valid ignored, normal fetch resumes after IDLE.

Source files
------------

// File: rtl/sram_bridge_arb.sv
// SRAM-style CPU port to split instruction/data cache bridge.
// Each CPU step issues at most one data access and one fetch, one after the
// other, and holds the pipeline with a single stall until both complete.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | first cycle after reset, nothing issued
// ARB   | pick the next pending op (data or fetch) and capture it
// DWAIT | data request held on the cache until data_valid / timeout
// IWAIT | fetch request held on the cache until inst_valid / timeout
// DONE  | one-cycle stall release, per-step flags cleared
module sram_bridge_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BE_W       = DATA_W / 8,
    parameter int DATA_FIRST = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] cpu_inst_addr,
    output logic [DATA_W-1:0] cpu_inst_rdata,
    input  logic [ADDR_W-1:0] cpu_data_addr,
    input  logic              cpu_data_ren,
    input  logic [BE_W-1:0]   cpu_data_wen,
    input  logic [DATA_W-1:0] cpu_data_wdata,
    output logic [DATA_W-1:0] cpu_data_rdata,
    output logic              cpu_stall,
    output logic              bus_err,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ren,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] inst_rd,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_ren,
    output logic [BE_W-1:0]   data_wen,
    output logic [DATA_W-1:0] data_wd,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_rd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_DWAIT = 3'd2;
    localparam logic [2:0] S_IWAIT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]       state;
    logic             d_done;
    logic             i_done;
    logic             stale;
    logic [CNT_W-1:0] wait_cnt;

    logic d_req;
    logic d_pend;
    logic d_pend_arb;
    logic tmo_hit;
    logic d_fin;
    logic i_fin;
    logic issue_d;
    logic issue_i;
    logic to_done;
    logic to_arb;

    // Decide which op to issue next and whether the current wait finishes.
    always_comb begin
        d_req      = cpu_data_ren | (|cpu_data_wen);
        d_pend     = d_req & ~d_done;
        d_pend_arb = d_pend & ~flush;
        tmo_hit    = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
        d_fin      = (state == S_DWAIT) && (data_valid || tmo_hit);
        i_fin      = (state == S_IWAIT) && (inst_valid || tmo_hit);
        issue_d    = 1'b0;
        issue_i    = 1'b0;
        to_done    = 1'b0;
        to_arb     = 1'b0;
        case (state)
            S_ARB: begin
                if (DATA_FIRST != 0) begin
                    if (d_pend_arb)   issue_d = 1'b1;
                    else if (!i_done) issue_i = 1'b1;
                    else              to_done = 1'b1;
                end else begin
                    if (!i_done)          issue_i = 1'b1;
                    else if (d_pend_arb)  issue_d = 1'b1;
                    else                  to_done = 1'b1;
                end
            end
            S_DWAIT: begin
                if (d_fin) begin
                    if (!i_done) issue_i = 1'b1;
                    else         to_done = 1'b1;
                end
            end
            S_IWAIT: begin
                if (i_fin) begin
                    // A stale fetch goes back through ARB to pick up the new address.
                    if (inst_valid && (stale || flush)) to_arb  = 1'b1;
                    else if (d_pend)                    issue_d = 1'b1;
                    else                                to_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer state, registered cache requests and CPU-side hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cpu_stall      <= 1'b1;
            bus_err        <= 1'b0;
            cpu_inst_rdata <= '0;
            cpu_data_rdata <= '0;
            inst_addr      <= '0;
            inst_ren       <= 1'b0;
            data_addr      <= '0;
            data_ren       <= 1'b0;
            data_wen       <= '0;
            data_wd        <= '0;
            d_done         <= 1'b0;
            i_done         <= 1'b0;
            stale          <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: state <= S_ARB;
                S_ARB: ;
                S_DWAIT: begin
                    if (d_fin) begin
                        data_ren <= 1'b0;
                        data_wen <= '0;
                        d_done   <= 1'b1;
                        if (!data_valid) begin
                            bus_err        <= 1'b1;
                            cpu_data_rdata <= '0;
                        end else if (data_ren) begin
                            cpu_data_rdata <= data_rd;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_IWAIT: begin
                    stale <= stale | flush;
                    if (i_fin) begin
                        inst_ren <= 1'b0;
                        stale    <= 1'b0;
                        if (!(inst_valid && (stale || flush))) begin
                            i_done <= 1'b1;
                            if (inst_valid) begin
                                cpu_inst_rdata <= inst_rd;
                            end else begin
                                bus_err        <= 1'b1;
                                cpu_inst_rdata <= '0;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    cpu_stall <= 1'b1;
                    d_done    <= 1'b0;
                    i_done    <= 1'b0;
                    state     <= S_ARB;
                end
                default: state <= S_IDLE;
            endcase

            if (issue_d) begin
                // Read wins over a simultaneous write; the write is dropped.
                data_addr <= cpu_data_addr;
                data_ren  <= cpu_data_ren;
                data_wen  <= cpu_data_ren ? '0 : cpu_data_wen;
                data_wd   <= cpu_data_wdata;
                wait_cnt  <= '0;
                state     <= S_DWAIT;
            end
            if (issue_i) begin
                inst_addr <= cpu_inst_addr;
                inst_ren  <= 1'b1;
                wait_cnt  <= '0;
                state     <= S_IWAIT;
            end
            if (to_done) begin
                cpu_stall <= 1'b0;
                state     <= S_DONE;
            end
            if (to_arb) begin
                state <= S_ARB;
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge_arb.sv
// Directed bench for sram_bridge_arb: instance A (data first, timeout 8) and
// instance B (fetch first, no timeout) share the CPU-side inputs.
module tb_sram_bridge_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] cpu_inst_addr = '0;
    logic [31:0] cpu_data_addr = '0;
    logic [31:0] cpu_data_wdata = '0;
    logic        cpu_data_ren = 1'b0;
    logic [3:0]  cpu_data_wen = '0;

    logic [31:0] a_cpu_inst_rdata, a_cpu_data_rdata, a_inst_addr, a_data_addr, a_data_wd;
    logic        a_cpu_stall, a_bus_err, a_inst_ren, a_data_ren;
    logic [3:0]  a_data_wen;
    logic        a_inst_valid = 1'b0, a_mdvalid = 1'b0, a_dforce = 1'b0;
    logic        a_data_valid;
    logic [31:0] a_ird = '0, a_drd = '0;
    int          a_idly = 1, a_ddly = 1, a_icnt = 0, a_dcnt = 0;

    logic [31:0] b_cpu_inst_rdata, b_cpu_data_rdata, b_inst_addr, b_data_addr, b_data_wd;
    logic        b_cpu_stall, b_bus_err, b_inst_ren, b_data_ren;
    logic [3:0]  b_data_wen;
    logic        b_inst_valid = 1'b0, b_data_valid = 1'b0;
    logic [31:0] b_ird = '0, b_drd = '0;
    int          b_idly = 1, b_ddly = 1, b_icnt = 0, b_dcnt = 0;

    assign a_data_valid = a_mdvalid | a_dforce;

    int passes = 0;
    int total  = 0;
    int n_iren, n_dren, n_dwen, n_berr;
    int n;

    sram_bridge_arb #(.DATA_FIRST(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .cpu_inst_addr(cpu_inst_addr), .cpu_inst_rdata(a_cpu_inst_rdata),
        .cpu_data_addr(cpu_data_addr), .cpu_data_ren(cpu_data_ren),
        .cpu_data_wen(cpu_data_wen), .cpu_data_wdata(cpu_data_wdata),
        .cpu_data_rdata(a_cpu_data_rdata), .cpu_stall(a_cpu_stall), .bus_err(a_bus_err),
        .inst_addr(a_inst_addr), .inst_ren(a_inst_ren), .inst_valid(a_inst_valid),
        .inst_rd(a_ird), .data_addr(a_data_addr), .data_ren(a_data_ren),
        .data_wen(a_data_wen), .data_wd(a_data_wd), .data_valid(a_data_valid),
        .data_rd(a_drd)
    );

    sram_bridge_arb #(.DATA_FIRST(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .cpu_inst_addr(cpu_inst_addr), .cpu_inst_rdata(b_cpu_inst_rdata),
        .cpu_data_addr(cpu_data_addr), .cpu_data_ren(cpu_data_ren),
        .cpu_data_wen(cpu_data_wen), .cpu_data_wdata(cpu_data_wdata),
        .cpu_data_rdata(b_cpu_data_rdata), .cpu_stall(b_cpu_stall), .bus_err(b_bus_err),
        .inst_addr(b_inst_addr), .inst_ren(b_inst_ren), .inst_valid(b_inst_valid),
        .inst_rd(b_ird), .data_addr(b_data_addr), .data_ren(b_data_ren),
        .data_wen(b_data_wen), .data_wd(b_data_wd), .data_valid(b_data_valid),
        .data_rd(b_drd)
    );

    always #5 clk = ~clk;

    // Cache model: valid in the dly-th cycle the request is visible; dly 0 = never.
    task automatic cache_model(input logic req, input int dly, inout int cnt, output logic vld);
        if (req) begin
            cnt = cnt + 1;
            vld = (dly != 0) && (cnt == dly);
        end else begin
            cnt = 0;
            vld = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        cache_model(a_inst_ren, a_idly, a_icnt, a_inst_valid);
        cache_model(a_data_ren | (|a_data_wen), a_ddly, a_dcnt, a_mdvalid);
        cache_model(b_inst_ren, b_idly, b_icnt, b_inst_valid);
        cache_model(b_data_ren | (|b_data_wen), b_ddly, b_dcnt, b_data_valid);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passes = passes + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Count stalled negedges until cpu_stall drops on the chosen instance.
    task automatic wait_release(input int which, input int bound, output int cnt);
        logic s;
        logic hit;
        cnt = 0; hit = 1'b0;
        n_iren = 0; n_dren = 0; n_dwen = 0; n_berr = 0;
        for (int k = 0; k < bound && !hit; k++) begin
            @(negedge clk);
            s = which ? b_cpu_stall : a_cpu_stall;
            n_iren += int'(which ? b_inst_ren : a_inst_ren);
            n_dren += int'(which ? b_data_ren : a_data_ren);
            n_dwen += int'(which ? (|b_data_wen) : (|a_data_wen));
            n_berr += int'(which ? b_bus_err : a_bus_err);
            if (!s) hit = 1'b1;
            else cnt = cnt + 1;
        end
        if (!hit) begin
            total = total + 1;
            $display("FAIL stall_release_timeout: stall still high after %0d cycles, expected release", bound);
        end
    endtask

    typedef struct {
        logic [31:0] iaddr;
        logic        dren;
        logic [3:0]  dwen;
        logic [31:0] daddr, wdata, ird, drd;
        int          idly, ddly;
        int          e_n;
        logic [31:0] e_irdata, e_drdata;
        int          e_dren, e_dwen, e_iren;
        logic [31:0] e_daddr, e_wd;
    } vec_t;

    vec_t tbl[5];
    logic e_ir [5];
    int   e_wen[5];
    logic e_st [5];

    initial begin
        // fetch only
        tbl[0] = '{32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h24080001, 32'h0, 1, 1,
                   3, 32'h24080001, 32'h0, 0, 0, 1, 32'h0, 32'h0};
        // load (3 wait cycles) then fetch
        tbl[1] = '{32'hBFC00004, 1'b1, 4'h0, 32'h80001000, 32'h0, 32'h8C820000, 32'hDEADBEEF, 1, 3,
                   6, 32'h8C820000, 32'hDEADBEEF, 3, 0, 1, 32'h80001000, 32'h0};
        // word store then slow fetch
        tbl[2] = '{32'hBFC00008, 1'b0, 4'hF, 32'h80000010, 32'h12345678, 32'hAC820004, 32'h0, 2, 2,
                   6, 32'hAC820004, 32'h0, 0, 2, 2, 32'h80000010, 32'h12345678};
        // read and write together: read wins, write dropped
        tbl[3] = '{32'hBFC0000C, 1'b1, 4'hF, 32'h80000030, 32'hAAAA5555, 32'h00000000, 32'h000000FF, 3, 1,
                   6, 32'h00000000, 32'h000000FF, 1, 0, 3, 32'h80000030, 32'hAAAA5555};
        // slow fetch, no data op: data regs untouched
        tbl[4] = '{32'hBFC00010, 1'b0, 4'h0, 32'h80009999, 32'hFFFFFFFF, 32'h3C010000, 32'h0, 4, 1,
                   6, 32'h3C010000, 32'h0, 0, 0, 4, 32'h0, 32'h0};

        // reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", a_cpu_stall, 1);
        chk("rst_ren", {a_inst_ren, a_data_ren, a_bus_err}, 0);
        chk("rst_wen", a_data_wen, 0);
        chk("rst_inst_addr", a_inst_addr, 0);
        chk("rst_data_addr", a_data_addr, 0);
        chk("rst_data_wd", a_data_wd, 0);
        chk("rst_inst_rdata", a_cpu_inst_rdata, 0);
        chk("rst_data_rdata", a_cpu_data_rdata, 0);

        // table-driven transactions on A
        for (int i = 0; i < 5; i++) begin
            cpu_inst_addr  = tbl[i].iaddr;
            cpu_data_ren   = tbl[i].dren;
            cpu_data_wen   = tbl[i].dwen;
            cpu_data_addr  = tbl[i].daddr;
            cpu_data_wdata = tbl[i].wdata;
            a_ird = tbl[i].ird; a_drd = tbl[i].drd;
            a_idly = tbl[i].idly; a_ddly = tbl[i].ddly;
            do_reset();
            wait_release(0, 40, n);
            chk($sformatf("v%0d_release_cycle", i), n, tbl[i].e_n);
            chk($sformatf("v%0d_inst_rdata", i), a_cpu_inst_rdata, tbl[i].e_irdata);
            chk($sformatf("v%0d_data_rdata", i), a_cpu_data_rdata, tbl[i].e_drdata);
            chk($sformatf("v%0d_dren_cycles", i), n_dren, tbl[i].e_dren);
            chk($sformatf("v%0d_dwen_cycles", i), n_dwen, tbl[i].e_dwen);
            chk($sformatf("v%0d_iren_cycles", i), n_iren, tbl[i].e_iren);
            chk($sformatf("v%0d_berr_cycles", i), n_berr, 0);
            chk($sformatf("v%0d_inst_addr", i), a_inst_addr, tbl[i].iaddr);
            chk($sformatf("v%0d_data_addr", i), a_data_addr, tbl[i].e_daddr);
            chk($sformatf("v%0d_data_wd", i), a_data_wd, tbl[i].e_wd);
            @(negedge clk);
            chk($sformatf("v%0d_stall_after_done", i), a_cpu_stall, 1);
        end

        // B (fetch first): load, then byte store that must not touch rdata
        cpu_inst_addr = 32'hBFC00000; cpu_data_ren = 1'b1; cpu_data_wen = 4'h0;
        cpu_data_addr = 32'h80000040; cpu_data_wdata = 32'h0;
        b_idly = 1; b_ddly = 1; b_drd = 32'h55AA55AA; b_ird = 32'h24020001;
        do_reset();
        wait_release(1, 40, n);
        chk("b_load_release_cycle", n, 4);
        chk("b_load_rdata", b_cpu_data_rdata, 32'h55AA55AA);
        cpu_inst_addr = 32'hBFC00008; cpu_data_ren = 1'b0; cpu_data_wen = 4'b0010;
        cpu_data_addr = 32'h80000020; cpu_data_wdata = 32'h0000AB00;
        b_ddly = 2; b_drd = 32'h0;
        e_ir  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e_wen = '{0, 0, 2, 2, 0};
        e_st  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("b_store_c%0d_inst_ren", c), b_inst_ren, e_ir[c]);
            chk($sformatf("b_store_c%0d_data_wen", c), b_data_wen, e_wen[c]);
            chk($sformatf("b_store_c%0d_stall", c), b_cpu_stall, e_st[c]);
            if (e_wen[c] != 0) chk($sformatf("b_store_c%0d_data_wd", c), b_data_wd, 32'h0000AB00);
        end
        chk("b_store_data_addr", b_data_addr, 32'h80000020);
        chk("b_store_rdata_kept", b_cpu_data_rdata, 32'h55AA55AA);

        // flush during the second IWAIT cycle: stale result dropped, refetch
        cpu_inst_addr = 32'hBFC00000; cpu_data_ren = 1'b0; cpu_data_wen = 4'h0;
        a_idly = 3; a_ird = 32'h11111111;
        do_reset();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1; cpu_inst_addr = 32'hBFC00380;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        a_ird = 32'h22222222;
        @(negedge clk);
        chk("flush_refetch_gap_ren", a_inst_ren, 0);
        chk("flush_refetch_gap_stall", a_cpu_stall, 1);
        wait_release(0, 40, n);
        chk("flush_release_cycle", n, 3);
        chk("flush_iren_cycles", n_iren, 3);
        chk("flush_inst_addr", a_inst_addr, 32'hBFC00380);
        chk("flush_inst_rdata", a_cpu_inst_rdata, 32'h22222222);

        // timeout: a good fetch first, then a fetch that never completes
        cpu_inst_addr = 32'hBFC00100; a_idly = 1; a_ird = 32'hCAFEF00D;
        do_reset();
        wait_release(0, 40, n);
        chk("tmo_pre_rdata", a_cpu_inst_rdata, 32'hCAFEF00D);
        a_idly = 0;
        wait_release(0, 40, n);
        chk("tmo_release_cycle", n, 9);
        chk("tmo_iren_cycles", n_iren, 8);
        chk("tmo_berr_at_done", a_bus_err, 1);
        chk("tmo_berr_cycles", n_berr, 1);
        chk("tmo_inst_rdata", a_cpu_inst_rdata, 0);
        @(negedge clk);
        chk("tmo_berr_pulse_end", a_bus_err, 0);

        // reset in the middle of DWAIT with a late data_valid
        cpu_inst_addr = 32'hBFC00010; cpu_data_ren = 1'b1; cpu_data_addr = 32'h80002000;
        a_ddly = 0; a_idly = 1; a_drd = 32'h99999999;
        do_reset();
        repeat (3) @(negedge clk);
        chk("rmid_dwait_ren", a_data_ren, 1);
        rst = 1'b1; a_dforce = 1'b1;
        @(negedge clk);
        chk("rmid_stall", a_cpu_stall, 1);
        chk("rmid_ren", {a_inst_ren, a_data_ren}, 0);
        chk("rmid_data_addr", a_data_addr, 0);
        rst = 1'b0; cpu_data_ren = 1'b0; a_ird = 32'h3C1DA000;
        @(negedge clk);
        chk("rmid_arb_ren", a_data_ren, 0);
        a_dforce = 1'b0;
        wait_release(0, 40, n);
        chk("rmid_release_cycle", n, 1);
        chk("rmid_dren_cycles", n_dren, 0);
        chk("rmid_inst_rdata", a_cpu_inst_rdata, 32'h3C1DA000);
        chk("rmid_data_rdata", a_cpu_data_rdata, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
